mul_iter32: RTL and testbench
=============================

Name: mul_iter32

Overview:
- Iterative radix-2 shift-add multiplier for the RV32M multiply group: MUL, MULH, MULHSU and MULHU.
- Sits in the execute stage beside the ALU.
- Instantiates one fulladder32 and uses it as its only partial-product adder. The block feeds fulladder32's operands every cycle and consumes its sum and carry.
- Takes one operation at a time with a start/busy/valid handshake. The result is ready a fixed 33 clock edges after the operation is accepted.

Parameters:
- none. Width is fixed at 32 by fulladder32.

Ports:
- clk_i     input   1   clock; all state updates on the rising edge
- rst_i     input   1   synchronous reset, active-high
- start_i   input   1   request to start an operation; sampled only when busy_o=0
- op_i      input   2   00 MUL, 01 MULH, 10 MULHSU, 11 MULHU; latched on accept
- a_i       input   32  rs1 operand; latched on accept
- b_i       input   32  rs2 operand; latched on accept
- busy_o    output  1   1 while an operation is in flight (CALC or FIX)
- valid_o   output  1   one-cycle pulse: result_o is valid this cycle
- result_o  output  32  result; holds its value until the next FIX completes

Behaviour:
- Clock and reset: one clock (clk_i); reset is synchronous and active-high (rst_i).
- Reset: state=IDLE; busy_o=0, valid_o=0, result_o=0; counter, accumulator and latched operands cleared.
- Reset mid-operation: rst_i overrides everything, including start_i. The in-flight operation is discarded and no valid_o is produced for it. The block can accept a new start on the first edge after rst_i falls.
- States: IDLE, CALC, FIX, DONE. busy_o=1 exactly in CALC and FIX.
- Accept: on an edge where start_i=1 and the state is IDLE or DONE (edge 0):
  - Latch op_i.
  - Signedness: a is signed for MULH and MULHSU; b is signed for MULH only. MUL uses the unsigned path, since the low word is the same either way.
  - Magnitudes: mcand = |a| and mplier = |b| as unsigned 32-bit values; 0x80000000 maps to 0x80000000.
  - neg = (signed a and a[31]) XOR (signed b and b[31]).
  - hi=0, lo=mplier, cnt=0, next state CALC.
- start_i while busy_o=1 is ignored and has no side effect.
- CALC, one step per edge, edges 1..32:
  - fulladder32 inputs: a_i=hi, b_i = lo[0] ? mcand : 0, carry_i=0.
  - {hi,lo} <= {carry_o, sum_o, lo[31:1]}. This is a 65-bit right shift that keeps bit 32 of the add.
  - cnt increments; after the edge where cnt reaches 31, next state is FIX.
- FIX, edge 33:
  - p = {hi,lo}; if neg, p = ~p + 1 (64-bit two's complement negate).
  - result_o = MUL ? p[31:0] : p[63:32].
  - valid_o=1; next state DONE.
- DONE:
  - valid_o is high for this single cycle only. It drops at the next edge unless a new accept follows FIX directly, which cannot happen because busy_o=1 during FIX.
  - Without start_i, the next state is IDLE.
- Back-to-back: start_i=1 during DONE is accepted on that edge. valid_o still falls and the new operation enters CALC.
- Latency: the accept edge is edge 0; valid_o is visible after edge 33. Throughput is one operation per 34 cycles when streamed.
- Operands a_i, b_i and op_i may change freely after the accept edge without affecting the result.
- result_o is never modified outside FIX and reset.

Test Plan:
- MUL, a=7, b=6 -> valid_o high exactly after edge 33 for 1 cycle; result_o=42; busy_o=1 on edges 1..33 only.
- a=b=0xFFFFFFFF:
  - MUL -> 0x00000001
  - MULH -> 0x00000000
  - MULHU -> 0xFFFFFFFE
- MULHSU, a=0x80000000, b=0xFFFFFFFF -> 0x80000000. MULH, a=b=0x80000000 -> 0x40000000 (most-negative magnitude path).
- Handshake ordering:
  - MUL 3*5 accepted; start_i held high with op MUL 9*9 during busy -> ignored, result 15.
  - Then start_i (MULHU 0x10000*0x10000) on the DONE cycle -> accepted; next result 0x00000001 after 33 more edges.
- Reset during CALC (cnt=10 of MUL 100*100) -> next cycle busy_o=0, valid_o=0, result_o=0; no valid_o pulse for the discarded operation.
  - Then MUL 100*100 -> 10000.
- Random regression: 1000 operations, random op and operands, with scoreboard against 64-bit reference product -> all match; valid_o count equals accept count.

Source files
------------

// File: rtl/mul_iter32_if.sv
// Handshake and operand bus of the iterative RV32M multiplier.
// The master side issues operations; the slave side is the multiplier.
interface mul_iter32_if;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    modport master (
        output start_i, op_i, a_i, b_i,
        input  busy_o, valid_o, result_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i,
        output busy_o, valid_o, result_o
    );
endinterface

// File: rtl/mul_iter32.sv
// Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Operates on magnitudes, then fixes the sign of the 64-bit product.
module fulladder32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        carry_i,
    output logic [31:0] sum_o,
    output logic        carry_o
);
    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'd0, carry_i};
endmodule

module mul_iter32 (
    input  logic         clk_i,
    input  logic         rst_i,
    mul_iter32_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_op;
    logic [31:0] r_mcand;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_result;
    logic [4:0]  r_cnt;
    logic        r_neg;
    logic        r_busy;
    logic        r_valid;

    logic        w_accept;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_add_b;
    logic [31:0] w_sum;
    logic        w_carry;
    logic [63:0] w_prod;

    assign w_accept = bus.start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // Next-state decode for the operation sequencer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start_i) begin
                    w_state_nxt = ST_CALC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (r_cnt == 5'd31) begin
                    w_state_nxt = ST_FIX;
                end else begin
                    w_state_nxt = ST_CALC;
                end
            end
            ST_FIX:  w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand signedness and magnitudes; -0x80000000 wraps to itself as intended
    always_comb begin
        w_a_neg = 1'b0;
        w_b_neg = 1'b0;
        case (bus.op_i)
            2'b01: begin
                w_a_neg = bus.a_i[31];
                w_b_neg = bus.b_i[31];
            end
            2'b10: begin
                w_a_neg = bus.a_i[31];
                w_b_neg = 1'b0;
            end
            default: begin
                w_a_neg = 1'b0;
                w_b_neg = 1'b0;
            end
        endcase
        w_a_mag = w_a_neg ? (~bus.a_i + 32'd1) : bus.a_i;
        w_b_mag = w_b_neg ? (~bus.b_i + 32'd1) : bus.b_i;
    end

    // Partial-product select and sign fix of the finished product
    always_comb begin
        w_add_b = r_lo[0] ? r_mcand : 32'd0;
        if (r_neg) begin
            w_prod = ~{r_hi, r_lo} + 64'd1;
        end else begin
            w_prod = {r_hi, r_lo};
        end
    end

    fulladder32 u_add (
        .a_i     (r_hi),
        .b_i     (w_add_b),
        .carry_i (1'b0),
        .sum_o   (w_sum),
        .carry_o (w_carry)
    );

    // State, status flags and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_op     <= 2'd0;
            r_mcand  <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_result <= 32'd0;
            r_cnt    <= 5'd0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_CALC) || (w_state_nxt == ST_FIX);
            r_valid <= (r_state == ST_FIX);
            if (w_accept) begin
                r_op    <= bus.op_i;
                r_mcand <= w_a_mag;
                r_neg   <= w_a_neg ^ w_b_neg;
                r_hi    <= 32'd0;
                r_lo    <= w_b_mag;
                r_cnt   <= 5'd0;
            end else if (r_state == ST_CALC) begin
                // 65-bit right shift keeps the adder carry as the new top bit
                {r_hi, r_lo} <= {w_carry, w_sum, r_lo[31:1]};
                r_cnt        <= r_cnt + 5'd1;
            end else if (r_state == ST_FIX) begin
                r_result <= (r_op == 2'b00) ? w_prod[31:0] : w_prod[63:32];
            end
        end
    end

    assign bus.busy_o   = r_busy;
    assign bus.valid_o  = r_valid;
    assign bus.result_o = r_result;
endmodule

// File: tb/tb_mul_iter32.sv
// Directed table, handshake/reset sequences and a random regression
// against a 64-bit reference product for mul_iter32.
module tb_mul_iter32;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   n_valid;
    int   n_accept;

    mul_iter32_if bus ();

    mul_iter32 dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.valid_o === 1'b1) n_valid++;
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string nm);
        logic busy_ok;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        @(posedge clk);
        busy_ok = 1'b1;
        for (int e = 0; e <= 32; e++) begin
            @(negedge clk);
            if (e == 0) begin
                bus.start_i = 1'b0;
                bus.op_i    = 2'($urandom_range(0, 3));
                bus.a_i     = $urandom;
                bus.b_i     = $urandom;
            end
            if (!(bus.busy_o === 1'b1 && bus.valid_o === 1'b0)) busy_ok = 1'b0;
        end
        check({nm, " busy window"}, 32'(busy_ok), 32'd1);
        @(negedge clk);
        check({nm, " valid/busy at edge33"}, {30'd0, bus.valid_o, bus.busy_o}, 32'd2);
        check({nm, " result"}, bus.result_o, exp);
        n_accept++;
        @(negedge clk);
        check({nm, " valid pulse width"}, {30'd0, bus.valid_o, bus.busy_o}, 32'd0);
    endtask

    initial begin
        logic ok;
        int   pre;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] pool [6];

        clk = 1'b0; rst = 1'b1;
        n_checks = 0; n_fail = 0; n_valid = 0; n_accept = 0;
        bus.start_i = 1'b0; bus.op_i = 2'd0; bus.a_i = 32'd0; bus.b_i = 32'd0;

        vecs[0]  = '{2'b00, 32'd7,          32'd6,          32'd42};
        vecs[1]  = '{2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001};
        vecs[2]  = '{2'b01, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000};
        vecs[3]  = '{2'b11, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE};
        vecs[4]  = '{2'b10, 32'h80000000,   32'hFFFFFFFF,   32'h80000000};
        vecs[5]  = '{2'b01, 32'h80000000,   32'h80000000,   32'h40000000};
        vecs[6]  = '{2'b00, 32'h12345678,   32'd0,          32'd0};
        vecs[7]  = '{2'b01, 32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF};
        vecs[8]  = '{2'b11, 32'h80000000,   32'd2,          32'h00000001};
        vecs[9]  = '{2'b10, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFF};
        vecs[10] = '{2'b00, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFE};
        vecs[11] = '{2'b10, 32'h00000002,   32'hFFFFFFFF,   32'h00000001};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset outputs", {bus.busy_o, bus.valid_o, bus.result_o[29:0]}, 32'd0);
        check("reset result", bus.result_o, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // start held during busy is ignored; start on the DONE cycle is accepted
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = 2'b00; bus.a_i = 32'd3; bus.b_i = 32'd5;
        @(posedge clk);
        @(negedge clk);
        bus.a_i = 32'd9; bus.b_i = 32'd9;
        ok = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            @(negedge clk);
            if (!(bus.busy_o === 1'b1 && bus.valid_o === 1'b0)) ok = 1'b0;
            if (e == 32) begin
                bus.op_i = 2'b11; bus.a_i = 32'h00010000; bus.b_i = 32'h00010000;
            end
        end
        check("hs busy while start held", 32'(ok), 32'd1);
        @(negedge clk);
        check("hs first valid", {31'd0, bus.valid_o}, 32'd1);
        check("hs first result", bus.result_o, 32'd15);
        @(negedge clk);
        check("hs b2b accept busy/valid", {30'd0, bus.busy_o, bus.valid_o}, 32'd2);
        check("hs result held", bus.result_o, 32'd15);
        bus.start_i = 1'b0;
        ok = 1'b1;
        repeat (32) begin
            @(negedge clk);
            if (!(bus.busy_o === 1'b1 && bus.valid_o === 1'b0)) ok = 1'b0;
        end
        check("hs second busy window", 32'(ok), 32'd1);
        @(negedge clk);
        check("hs second valid", {31'd0, bus.valid_o}, 32'd1);
        check("hs second result", bus.result_o, 32'd1);
        n_accept += 2;
        @(negedge clk);
        check("hs second pulse width", {31'd0, bus.valid_o}, 32'd0);

        // reset in the middle of CALC discards the operation
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = 2'b00; bus.a_i = 32'd100; bus.b_i = 32'd100;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset busy/valid", {30'd0, bus.busy_o, bus.valid_o}, 32'd0);
        check("midreset result", bus.result_o, 32'd0);
        rst = 1'b0;
        pre = n_valid;
        repeat (40) @(negedge clk);
        check("midreset no valid", 32'(n_valid - pre), 32'd0);
        run_op(2'b00, 32'd100, 32'd100, 32'd10000, "after reset");

        pool[0] = 32'h00000000; pool[1] = 32'hFFFFFFFF; pool[2] = 32'h80000000;
        pool[3] = 32'h7FFFFFFF; pool[4] = 32'h00000001; pool[5] = 32'h80000001;
        for (int i = 0; i < 1000; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
            run_op(rop, ra, rb, ref_mul(rop, ra, rb), $sformatf("rnd%0d op%0d %h*%h", i, rop, ra, rb));
        end

        check("valid count vs accepts", 32'(n_valid), 32'(n_accept));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
